// File: rtl/jt5205_player.sv
// jt5205_player
//   ADPCM playback sequencer for the jt5205 decoder. A start pulse latches a
//   byte range [start_addr..end_addr] (inclusive, wrapping modulo 2^AW). Bytes
//   are fetched from sample ROM through a cs/ok handshake into a two-entry queue
//   (cur + buf). Each byte is split into two 4-bit codes, one per sample_stb.
//   The decoder is held in reset whenever nothing is playing.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   sample_stb          one-cycle pulse at the sample rate
//   start, stop         playback control pulses (stop has priority)
//   start_addr/end_addr byte range, captured on an accepted start
//   rom_addr/rom_cs     ROM request (cs held until rom_ok)
//   rom_data/rom_ok     ROM response (data valid when cs && ok)
//   adpcm_din           4-bit code to the decoder
//   adpcm_rst           decoder reset, active high
//   busy                playback in progress
//   done                one-cycle pulse on normal end of playback
//   underrun            one-cycle pulse when a strobe finds no data
module jt5205_player #(
    parameter int AW       = 16,
    parameter bit HI_FIRST = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sample_stb,
    input  logic          start,
    input  logic          stop,
    input  logic [AW-1:0] start_addr,
    input  logic [AW-1:0] end_addr,
    output logic [AW-1:0] rom_addr,
    output logic          rom_cs,
    input  logic [7:0]    rom_data,
    input  logic          rom_ok,
    output logic [3:0]    adpcm_din,
    output logic          adpcm_rst,
    output logic          busy,
    output logic          done,
    output logic          underrun
);

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, TAIL} state_t;

    state_t        state_reg, state_next;

    // fetch side
    logic [AW-1:0] addr_reg;
    logic [AW-1:0] end_reg;
    logic          cs_reg;
    logic          more_reg;        // bytes remain to be fetched

    // two-entry byte queue
    logic [7:0]    cur_data_reg, buf_data_reg;
    logic          cur_valid_reg, buf_valid_reg;
    logic          cur_last_reg, buf_last_reg;

    // playback outputs
    logic          ph_reg, ph_next;
    logic [3:0]    din_reg, din_next;
    logic          arst_reg, arst_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;
    logic          underrun_reg, underrun_next;

    logic          stop_go, start_go, flush, stb_play, consume, fetch_go, rom_take;
    logic [3:0]    first_nib, second_nib;

    // stop only matters while active and always beats start
    assign stop_go   = stop && (state_reg != IDLE);
    assign start_go  = start && !stop;
    assign flush     = stop_go || start_go;
    // a strobe coinciding with start/stop is dropped
    assign stb_play  = sample_stb && (state_reg == PLAY) && !flush;
    assign consume   = stb_play && ph_reg;
    assign fetch_go  = !cs_reg && !buf_valid_reg && more_reg &&
                       ((state_reg == LOAD) || (state_reg == PLAY));
    // rom_ok without an outstanding request is ignored
    assign rom_take  = cs_reg && rom_ok;

    assign first_nib  = HI_FIRST ? cur_data_reg[7:4] : cur_data_reg[3:0];
    assign second_nib = HI_FIRST ? cur_data_reg[3:0] : cur_data_reg[7:4];

    // next-state logic
    always_comb begin
        state_next = state_reg;
        if (stop_go) begin
            state_next = IDLE;
        end else if (start_go) begin
            state_next = LOAD;
        end else begin
            case (state_reg)
                LOAD:    if (cur_valid_reg) state_next = PLAY;
                PLAY:    if (consume && cur_last_reg) state_next = TAIL;
                TAIL:    if (sample_stb) state_next = IDLE;
                default: state_next = state_reg;
            endcase
        end
    end

    // next values for the registered outputs
    always_comb begin
        ph_next       = ph_reg;
        din_next      = din_reg;
        arst_next     = arst_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;
        underrun_next = 1'b0;
        if (stop_go) begin
            arst_next = 1'b1;
            busy_next = 1'b0;
            ph_next   = 1'b0;
        end else if (start_go) begin
            // fresh start or restart: decoder held in reset until data arrives
            arst_next = 1'b1;
            busy_next = 1'b1;
            ph_next   = 1'b0;
        end else begin
            case (state_reg)
                LOAD: begin
                    if (cur_valid_reg) begin
                        arst_next = 1'b0;
                        ph_next   = 1'b0;
                    end
                end
                PLAY: begin
                    if (stb_play) begin
                        if (ph_reg) begin
                            din_next = second_nib;
                            ph_next  = 1'b0;
                        end else if (cur_valid_reg) begin
                            din_next = first_nib;
                            ph_next  = 1'b1;
                        end else begin
                            din_next      = 4'd0;
                            underrun_next = 1'b1;
                        end
                    end
                end
                TAIL: begin
                    if (sample_stb) begin
                        arst_next = 1'b1;
                        busy_next = 1'b0;
                        done_next = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            ph_reg       <= 1'b0;
            din_reg      <= 4'd0;
            arst_reg     <= 1'b1;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            underrun_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ph_reg       <= ph_next;
            din_reg      <= din_next;
            arst_reg     <= arst_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            underrun_reg <= underrun_next;
        end
    end

    // ROM fetch and byte queue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg      <= '0;
            end_reg       <= '0;
            cs_reg        <= 1'b0;
            more_reg      <= 1'b0;
            cur_data_reg  <= 8'd0;
            cur_valid_reg <= 1'b0;
            cur_last_reg  <= 1'b0;
            buf_data_reg  <= 8'd0;
            buf_valid_reg <= 1'b0;
            buf_last_reg  <= 1'b0;
        end else if (flush) begin
            // drop any in-flight request; its late ok is ignored because cs is low
            cs_reg        <= 1'b0;
            cur_valid_reg <= 1'b0;
            buf_valid_reg <= 1'b0;
            more_reg      <= start_go;
            if (start_go) begin
                addr_reg <= start_addr;
                end_reg  <= end_addr;
            end
        end else begin
            if (rom_take) begin
                buf_data_reg  <= rom_data;
                buf_valid_reg <= 1'b1;
                buf_last_reg  <= (addr_reg == end_reg);
                more_reg      <= (addr_reg != end_reg);
                addr_reg      <= addr_reg + AW'(1);
                cs_reg        <= 1'b0;
            end else if (fetch_go) begin
                cs_reg <= 1'b1;
            end
            // a request is only issued with buf empty, so a ROM write and a
            // buf->cur move never coincide
            if (consume) begin
                cur_valid_reg <= 1'b0;
            end else if (!cur_valid_reg && buf_valid_reg) begin
                cur_data_reg  <= buf_data_reg;
                cur_last_reg  <= buf_last_reg;
                cur_valid_reg <= 1'b1;
                buf_valid_reg <= 1'b0;
            end
        end
    end

    assign rom_addr  = addr_reg;
    assign rom_cs    = cs_reg;
    assign adpcm_din = din_reg;
    assign adpcm_rst = arst_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign underrun  = underrun_reg;

endmodule
